atm_session_engine: RTL and testbench
=====================================

Name: atm_session_engine

Overview:
- Parametrised next-generation ATM transaction core.
- Holds an internal account store of NUM_ACCTS entries, each with a PIN, a balance and a lock bit.
- Runs a full card session in one clocked FSM: card insert → lock check → PIN entry with retry/lockout → repeated operations (deposit, withdraw, inquiry) → eject.
- Adds per-session withdraw limit, overflow rejection, user cancel and a provisioning port; sits directly under the ATM top level.

Parameters:
- NUM_ACCTS, 32, number of accounts; address width AW = $clog2(NUM_ACCTS)
- PIN_W, 4, PIN width
- BAL_W, 10, balance and amount width
- MAX_TRIES, 3, wrong PINs before the account locks (≥1)
- SESSION_LIMIT, 500, maximum cumulative withdrawal per session
- TIMEOUT_CYC, 1023, idle cycles before abort (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- card_valid  in  1  card inserted, one-cycle pulse, qualifies card_addr
- card_addr  in  AW  account index from the card
- pin_valid  in  1  pulse, qualifies pin_user
- pin_user  in  PIN_W  entered PIN
- op_valid  in  1  pulse, qualifies op_sel/amount
- op_sel  in  2  00 eject, 01 deposit, 10 withdraw, 11 inquiry
- amount  in  BAL_W  transaction amount
- user_approve  in  1  confirm pending deposit/withdraw
- user_cancel  in  1  abort session from any non-IDLE state
- prog_we  in  1  provisioning write, honoured only in IDLE
- prog_addr  in  AW  provisioning address
- prog_pin  in  PIN_W  provisioning PIN
- prog_bal  in  BAL_W  provisioning balance
- busy  out  1  high whenever state ≠ IDLE
- state_o  out  3  encoded FSM state
- pin_ok  out  1  PIN accepted for the current session
- txn_done  out  1  one-cycle pulse at the end of each operation or session abort
- err_code  out  3  0 ok, 1 bad PIN, 2 locked, 3 insufficient funds, 4 limit exceeded, 5 overflow, 6 cancelled, 7 timeout; valid with txn_done
- new_balance  out  BAL_W  balance after the last operation; registered
- cash_out  out  BAL_W  dispensed amount; nonzero only in the txn_done cycle of a successful withdraw

Behaviour:
- Reset: all outputs 0; state IDLE; every account has PIN 0, balance 0 and lock 0; try and session counters 0.
- IDLE (0):
  - prog_we writes the PIN and balance at prog_addr and clears its lock bit, one-cycle write.
  - card_valid latches card_addr → CHK (1).
  - card_valid has priority over prog_we in the same cycle; that prog write is dropped.
  - prog_we outside IDLE is ignored.
- CHK (1), one cycle:
  - Lock set → txn_done, err=2, → IDLE.
  - Otherwise clear the try counter → PIN (2).
- PIN (2), on pin_valid:
  - Match → pin_ok=1 → OP (3).
  - Mismatch → try counter +1, txn_done, err=1, stay in PIN.
  - When the counter reaches MAX_TRIES: set the lock bit, txn_done, err=2 (overrides err=1), → IDLE.
- OP (3), on op_valid:
  - 00: txn_done err=0 → IDLE.
  - 11: new_balance = stored balance, txn_done err=0, stay in OP.
  - 01/10: latch op and amount → CONF (4).
- CONF (4): user_approve → EXEC (5).
- EXEC (5), one cycle, checks in this order:
  - Withdraw with amount > balance → err=3.
  - Withdraw with session_sum + amount > SESSION_LIMIT → err=4.
  - Deposit with balance + amount ≥ 2^BAL_W → err=5; the comparison uses BAL_W+1 bits, no wrap.
  - Otherwise update the stored balance, new_balance, session_sum and cash_out (withdraw only); err=0.
  - Always pulse txn_done and return to OP. On any error the balance is unchanged.
- amount = 0 is legal: success, balance unchanged.
- session_sum is BAL_W+1 bits and clears on every entry to IDLE.
- user_cancel in PIN/OP/CONF → txn_done err=6 → IDLE; no store change, and the pending op is discarded.
- user_cancel takes priority over a simultaneous pin_valid, op_valid or user_approve.
- user_cancel is ignored in CHK and EXEC.
- pin_ok clears on IDLE entry.
- card_valid outside IDLE is ignored.
- Reset asserted mid-session returns to IDLE immediately; provisioned data is lost.
- Latency: card_valid → PIN state in 2 cycles; user_approve → txn_done in 2 cycles.

Optional Feature:
- Macro: ATM_TIMEOUT_EN.
- Defined:
  - A counter clears on any input pulse (card_valid, pin_valid, op_valid, user_approve) and increments in PIN/OP/CONF.
  - When it reaches TIMEOUT_CYC: txn_done err=7 → IDLE, pending op discarded.
  - user_cancel takes priority over a timeout in the same cycle.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- prog acct 5 PIN=4'h7 bal=300; card 5, PIN 7, withdraw 120, approve → txn_done err=0, cash_out=120, new_balance=180; eject → busy=0.
- Acct 5 PIN 7: enter PINs 1, 2, 3 → err=1, err=1, then err=2; state IDLE. Re-insert card 5 → err=2 after CHK. prog acct 5 → lock cleared.
- bal=300, withdraw 301 → err=3, balance 300; withdraw 300 then 250 with bal raised by deposit 400 → second gives err=4 (sum 550 > 500).
- bal=1000 (BAL_W=10), deposit 24 → err=5, balance 1000; deposit 23 → new_balance=1023, err=0.
- In CONF assert user_cancel and user_approve together → err=6, balance unchanged, IDLE; inquiry in a fresh session shows the same balance.
- ATM_TIMEOUT_EN, TIMEOUT_CYC=16: sit in OP for 16 idle cycles → txn_done err=7, busy=0; pulsing op_valid every 10 cycles never times out.

Source files
------------

// File: rtl/atm_session_engine.sv
// atm_session_engine: ATM card-session core with an internal account store.
// The account store, the session FSM and the outputs are all registered in one clock domain.
// Optional build macro: ATM_TIMEOUT_EN adds an idle-cycle abort (error 7)
// after TIMEOUT_CYC quiet cycles. Without the macro the FSM waits indefinitely.
//
// Input pulse semantics: card_valid, pin_valid, op_valid, user_approve and
// user_cancel are one-cycle strobes. Each strobe qualifies its data inputs
// only in the cycle it is high. It is acted on only in the state that
// consumes it; in every other state it is dropped. There is no back-pressure:
// busy and state_o tell the driver which strobe is currently meaningful.
module atm_session_engine #(
  parameter int NUM_ACCTS     = 32,
  parameter int PIN_W         = 4,
  parameter int BAL_W         = 10,
  parameter int MAX_TRIES     = 3,
  parameter int SESSION_LIMIT = 500,
  parameter int TIMEOUT_CYC   = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         card_valid,
  input  logic [$clog2(NUM_ACCTS)-1:0] card_addr,
  input  logic                         pin_valid,
  input  logic [PIN_W-1:0]             pin_user,
  input  logic                         op_valid,
  input  logic [1:0]                   op_sel,
  input  logic [BAL_W-1:0]             amount,
  input  logic                         user_approve,
  input  logic                         user_cancel,
  input  logic                         prog_we,
  input  logic [$clog2(NUM_ACCTS)-1:0] prog_addr,
  input  logic [PIN_W-1:0]             prog_pin,
  input  logic [BAL_W-1:0]             prog_bal,
  output logic                         busy,
  output logic [2:0]                   state_o,
  output logic                         pin_ok,
  output logic                         txn_done,
  output logic [2:0]                   err_code,
  output logic [BAL_W-1:0]             new_balance,
  output logic [BAL_W-1:0]             cash_out
);

  localparam int AW = $clog2(NUM_ACCTS);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0]      TRIES_MAX = TW'(MAX_TRIES);
  localparam logic [BAL_W+1:0]   LIMIT_EXT = (BAL_W + 2)'(SESSION_LIMIT);

  localparam logic [2:0] E_OK      = 3'd0;
  localparam logic [2:0] E_BAD_PIN = 3'd1;
  localparam logic [2:0] E_LOCKED  = 3'd2;
  localparam logic [2:0] E_FUNDS   = 3'd3;
  localparam logic [2:0] E_LIMIT   = 3'd4;
  localparam logic [2:0] E_OVFL    = 3'd5;
  localparam logic [2:0] E_CANCEL  = 3'd6;
  localparam logic [2:0] E_TIMEOUT = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CHK  = 3'd1,
    S_PIN  = 3'd2,
    S_OP   = 3'd3,
    S_CONF = 3'd4,
    S_EXEC = 3'd5
  } state_t;

  state_t state;

  // Account store
  logic [PIN_W-1:0] pin_mem  [NUM_ACCTS];
  logic [BAL_W-1:0] bal_mem  [NUM_ACCTS];
  logic             lock_mem [NUM_ACCTS];

  // Session context
  logic [AW-1:0]    cur_addr;
  logic [TW-1:0]    tries;
  logic             op_wd;        // 1 = withdraw, 0 = deposit
  logic [BAL_W-1:0] op_amt;
  logic [BAL_W:0]   session_sum;  // cumulative withdrawals this session

  logic [BAL_W-1:0] cur_bal;
  logic [PIN_W-1:0] cur_pin;
  logic [TW-1:0]    tries_next;
  logic [BAL_W:0]   dep_sum;
  logic [BAL_W+1:0] wd_total;
  logic             over_funds;
  logic             over_limit;
  logic             overflow;
  logic             waiting;
  logic             cancel_hit;
  logic             timeout_hit;

  assign busy    = (state != S_IDLE);
  assign state_o = state;

  assign cur_bal    = bal_mem[cur_addr];
  assign cur_pin    = pin_mem[cur_addr];
  assign tries_next = tries + 1'b1;
  // Sums are widened so that neither the overflow test nor the limit test can wrap.
  assign dep_sum    = {1'b0, cur_bal} + {1'b0, op_amt};
  assign wd_total   = {1'b0, session_sum} + {2'b00, op_amt};
  assign over_funds = (op_amt > cur_bal);
  assign over_limit = (wd_total > LIMIT_EXT);
  assign overflow   = dep_sum[BAL_W];

  // States where the session is waiting on the user; cancel and timeout apply only here.
  assign waiting    = (state == S_PIN) || (state == S_OP) || (state == S_CONF);
  assign cancel_hit = waiting && user_cancel;

`ifdef ATM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] idle_cnt;
  logic          any_pulse;

  assign any_pulse   = card_valid | pin_valid | op_valid | user_approve;
  assign timeout_hit = waiting && (idle_cnt == CW'(TIMEOUT_CYC));

  // Idle-cycle counter: restarts on any user strobe, runs only while waiting on the user.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (any_pulse || !waiting) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Session FSM plus account store updates; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cur_addr    <= '0;
      tries       <= '0;
      op_wd       <= 1'b0;
      op_amt      <= '0;
      session_sum <= '0;
      pin_ok      <= 1'b0;
      txn_done    <= 1'b0;
      err_code    <= E_OK;
      new_balance <= '0;
      cash_out    <= '0;
      for (int i = 0; i < NUM_ACCTS; i++) begin
        pin_mem[i]  <= '0;
        bal_mem[i]  <= '0;
        lock_mem[i] <= 1'b0;
      end
    end else begin
      txn_done <= 1'b0;
      cash_out <= '0;
      case (state)
        S_IDLE: begin
          // A card wins over a same-cycle provisioning write, which is dropped.
          if (card_valid) begin
            cur_addr <= card_addr;
            state    <= S_CHK;
          end else if (prog_we) begin
            pin_mem[prog_addr]  <= prog_pin;
            bal_mem[prog_addr]  <= prog_bal;
            lock_mem[prog_addr] <= 1'b0;
          end
        end

        S_CHK: begin
          if (lock_mem[cur_addr]) begin
            txn_done    <= 1'b1;
            err_code    <= E_LOCKED;
            pin_ok      <= 1'b0;
            session_sum <= '0;
            state       <= S_IDLE;
          end else begin
            tries <= '0;
            state <= S_PIN;
          end
        end

        S_PIN: begin
          if (cancel_hit || timeout_hit) begin
            txn_done    <= 1'b1;
            err_code    <= cancel_hit ? E_CANCEL : E_TIMEOUT;
            pin_ok      <= 1'b0;
            session_sum <= '0;
            state       <= S_IDLE;
          end else if (pin_valid) begin
            if (pin_user == cur_pin) begin
              pin_ok <= 1'b1;
              state  <= S_OP;
            end else if (tries_next == TRIES_MAX) begin
              // Final wrong PIN locks the account and ends the session.
              tries              <= tries_next;
              lock_mem[cur_addr] <= 1'b1;
              txn_done           <= 1'b1;
              err_code           <= E_LOCKED;
              pin_ok             <= 1'b0;
              session_sum        <= '0;
              state              <= S_IDLE;
            end else begin
              tries    <= tries_next;
              txn_done <= 1'b1;
              err_code <= E_BAD_PIN;
            end
          end
        end

        S_OP: begin
          if (cancel_hit || timeout_hit) begin
            txn_done    <= 1'b1;
            err_code    <= cancel_hit ? E_CANCEL : E_TIMEOUT;
            pin_ok      <= 1'b0;
            session_sum <= '0;
            state       <= S_IDLE;
          end else if (op_valid) begin
            case (op_sel)
              2'b00: begin
                txn_done    <= 1'b1;
                err_code    <= E_OK;
                pin_ok      <= 1'b0;
                session_sum <= '0;
                state       <= S_IDLE;
              end
              2'b11: begin
                new_balance <= cur_bal;
                txn_done    <= 1'b1;
                err_code    <= E_OK;
              end
              default: begin
                op_wd  <= op_sel[1];
                op_amt <= amount;
                state  <= S_CONF;
              end
            endcase
          end
        end

        S_CONF: begin
          if (cancel_hit || timeout_hit) begin
            txn_done    <= 1'b1;
            err_code    <= cancel_hit ? E_CANCEL : E_TIMEOUT;
            pin_ok      <= 1'b0;
            session_sum <= '0;
            state       <= S_IDLE;
          end else if (user_approve) begin
            state <= S_EXEC;
          end
        end

        S_EXEC: begin
          // Error checks in priority order; any error leaves the store untouched.
          txn_done <= 1'b1;
          state    <= S_OP;
          if (op_wd && over_funds) begin
            err_code <= E_FUNDS;
          end else if (op_wd && over_limit) begin
            err_code <= E_LIMIT;
          end else if (!op_wd && overflow) begin
            err_code <= E_OVFL;
          end else begin
            err_code <= E_OK;
            if (op_wd) begin
              bal_mem[cur_addr] <= cur_bal - op_amt;
              new_balance       <= cur_bal - op_amt;
              session_sum       <= wd_total[BAL_W:0];
              cash_out          <= op_amt;
            end else begin
              bal_mem[cur_addr] <= dep_sum[BAL_W-1:0];
              new_balance       <= dep_sum[BAL_W-1:0];
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_session_engine.sv
// tb_atm_session_engine: randomized and directed session stimulus for
// atm_session_engine, checked against an account-level reference model.
// Build with ATM_TIMEOUT_EN defined to exercise the idle abort.
module tb_atm_session_engine;

  localparam int NA = 32;
  localparam int PW = 4;
  localparam int BW = 10;
  localparam int MT = 3;
  localparam int SL = 500;
  localparam int W  = 24;   // {chk_bal, err[3], cash[10], bal[10]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          card_valid, pin_valid, op_valid, user_approve, user_cancel, prog_we;
  logic [4:0]    card_addr, prog_addr;
  logic [PW-1:0] pin_user, prog_pin;
  logic [1:0]    op_sel;
  logic [BW-1:0] amount, prog_bal;
  logic          busy, pin_ok, txn_done;
  logic [2:0]    state_o, err_code;
  logic [BW-1:0] new_balance, cash_out;

  atm_session_engine #(
    .NUM_ACCTS(NA), .PIN_W(PW), .BAL_W(BW), .MAX_TRIES(MT),
    .SESSION_LIMIT(SL), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .card_valid(card_valid), .card_addr(card_addr),
    .pin_valid(pin_valid), .pin_user(pin_user),
    .op_valid(op_valid), .op_sel(op_sel), .amount(amount),
    .user_approve(user_approve), .user_cancel(user_cancel),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_pin(prog_pin), .prog_bal(prog_bal),
    .busy(busy), .state_o(state_o), .pin_ok(pin_ok), .txn_done(txn_done),
    .err_code(err_code), .new_balance(new_balance), .cash_out(cash_out)
  );

  // ---------------- reference model ----------------
  int ref_pin  [NA];
  int ref_bal  [NA];
  bit ref_lock [NA];
  int m_addr, m_tries, m_sum, m_phase;   // m_phase: 0 idle, 2 pin entry, 3 operations

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input bit chk, input int err, input int cash, input int bal);
    return {chk, 3'(err), 10'(cash), 10'(bal)};
  endfunction

  // Every txn_done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && txn_done) begin
      if (exp_q.size() == 0) begin
        check("txn_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("err_code", 32'(err_code), 32'(e[22:20]));
        check("cash_out", 32'(cash_out), 32'(e[19:10]));
        if (e[23]) check("new_balance", 32'(new_balance), 32'(e[9:0]));
      end
    end
  end

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      check("txn_missing", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_card(input int a);
    @(negedge clk); card_valid = 1'b1; card_addr = 5'(a);
    @(negedge clk); card_valid = 1'b0;
  endtask

  task automatic pulse_pin(input int p, input bit canc);
    @(negedge clk); pin_valid = 1'b1; pin_user = PW'(p); user_cancel = canc;
    @(negedge clk); pin_valid = 1'b0; user_cancel = 1'b0;
  endtask

  task automatic pulse_op(input int sel, input int amt, input bit canc);
    @(negedge clk); op_valid = 1'b1; op_sel = 2'(sel); amount = BW'(amt); user_cancel = canc;
    @(negedge clk); op_valid = 1'b0; user_cancel = 1'b0;
  endtask

  task automatic pulse_confirm(input bit appr, input bit canc);
    @(negedge clk); user_approve = appr; user_cancel = canc;
    @(negedge clk); user_approve = 1'b0; user_cancel = 1'b0;
  endtask

  task automatic prog(input int a, input int p, input int b, input bit with_card, input int ca);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 5'(a); prog_pin = PW'(p); prog_bal = BW'(b);
    card_valid = with_card; card_addr = 5'(ca);
    @(negedge clk); prog_we = 1'b0; card_valid = 1'b0;
    // Provisioning only lands in IDLE and loses to a simultaneous card.
    if (m_phase == 0 && !with_card) begin
      ref_pin[a] = p; ref_bal[a] = b; ref_lock[a] = 1'b0;
    end
  endtask

  // ---------------- session-level model steps ----------------
  task automatic end_session();
    m_phase = 0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_pin_ok", 32'(pin_ok), 32'd0);
  endtask

  task automatic sess_card(input int a);
    m_addr = a;
    if (ref_lock[a]) begin
      exp_q.push_back(mk(0, 2, 0, 0));
      pulse_card(a);
      drain();
      end_session();
    end else begin
      pulse_card(a);
      @(negedge clk);
      check("card_to_pin_state", 32'(state_o), 32'd2);
      m_tries = 0; m_sum = 0; m_phase = 2;
    end
  endtask

  task automatic sess_pin(input int p);
    if (p == ref_pin[m_addr]) begin
      pulse_pin(p, 1'b0);
      check("pin_ok_set", 32'(pin_ok), 32'd1);
      check("op_state", 32'(state_o), 32'd3);
      m_phase = 3;
    end else begin
      m_tries++;
      if (m_tries == MT) begin
        ref_lock[m_addr] = 1'b1;
        exp_q.push_back(mk(0, 2, 0, 0));
        pulse_pin(p, 1'b0);
        drain();
        end_session();
      end else begin
        exp_q.push_back(mk(0, 1, 0, 0));
        pulse_pin(p, 1'b0);
        drain();
      end
    end
  endtask

  task automatic sess_pin_cancel();
    exp_q.push_back(mk(0, 6, 0, 0));
    pulse_pin(ref_pin[m_addr], 1'b1);
    drain();
    end_session();
  endtask

  // mode: 0 approve, 1 cancel in CONF, 2 cancel+approve in CONF, 3 cancel with op_valid in OP
  task automatic sess_op(input int sel, input int amt, input int mode);
    int bal, err, cash, nb;
    bal = ref_bal[m_addr];
    if (mode == 3) begin
      exp_q.push_back(mk(0, 6, 0, 0));
      pulse_op(sel, amt, 1'b1);
      drain();
      end_session();
      return;
    end
    if (sel == 0) begin
      exp_q.push_back(mk(0, 0, 0, 0));
      pulse_op(0, 0, 1'b0);
      drain();
      end_session();
      return;
    end
    if (sel == 3) begin
      exp_q.push_back(mk(1, 0, 0, bal));
      pulse_op(3, 0, 1'b0);
      drain();
      return;
    end
    pulse_op(sel, amt, 1'b0);
    check("conf_state", 32'(state_o), 32'd4);
    if (mode != 0) begin
      exp_q.push_back(mk(0, 6, 0, 0));
      pulse_confirm(mode == 2, 1'b1);
      drain();
      end_session();
      return;
    end
    err = 0; cash = 0; nb = bal;
    if (sel == 2 && amt > bal)              err = 3;
    else if (sel == 2 && m_sum + amt > SL)  err = 4;
    else if (sel == 1 && bal + amt >= 1024) err = 5;
    else if (sel == 2) begin nb = bal - amt; cash = amt; m_sum += amt; end
    else nb = bal + amt;
    ref_bal[m_addr] = nb;
    exp_q.push_back(mk(err == 0, err, cash, nb));
    pulse_confirm(1'b1, 1'b0);
    check("approve_not_early", 32'(txn_done), 32'd0);
    drain();
    check("exec_back_to_op", 32'(state_o), 32'd3);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int a, r, n, amt, bal;
    card_valid = 0; pin_valid = 0; op_valid = 0; user_approve = 0; user_cancel = 0; prog_we = 0;
    card_addr = 0; prog_addr = 0; pin_user = 0; prog_pin = 0; op_sel = 0; amount = 0; prog_bal = 0;
    for (int i = 0; i < NA; i++) begin ref_pin[i] = 0; ref_bal[i] = 0; ref_lock[i] = 0; end
    m_addr = 0; m_tries = 0; m_sum = 0; m_phase = 0;

    // Reset state
    cyc(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_pin_ok", 32'(pin_ok), 32'd0);
    check("rst_txn_done", 32'(txn_done), 32'd0);
    check("rst_err", 32'(err_code), 32'd0);
    check("rst_new_bal", 32'(new_balance), 32'd0);
    check("rst_cash", 32'(cash_out), 32'd0);
    rst = 1'b0;
    cyc(2);

    // Basic withdraw and eject
    prog(5, 7, 300, 0, 0);
    sess_card(5); sess_pin(7);
    sess_op(2, 120, 0);
    sess_op(0, 0, 0);

    // Lockout, locked re-insert, unlock by provisioning
    sess_card(5); sess_pin(1); sess_pin(2); sess_pin(3);
    check("locked_state", 32'(state_o), 32'd0);
    sess_card(5);
    prog(5, 7, 300, 0, 0);
    sess_card(5); sess_pin(7);

    // Insufficient funds, then session limit
    sess_op(2, 301, 0);
    sess_op(3, 0, 0);
    sess_op(2, 300, 0);
    sess_op(1, 400, 0);
    sess_op(2, 250, 0);
    sess_op(0, 0, 0);

    // Overflow boundary
    prog(6, 3, 1000, 0, 0);
    sess_card(6); sess_pin(3);
    sess_op(1, 24, 0);
    sess_op(1, 23, 0);
    sess_op(0, 0, 0);

    // Cancel beats approve; fresh session sees the same balance; zero amount
    sess_card(6); sess_pin(3);
    sess_op(1, 5, 2);
    sess_card(6); sess_pin(3);
    sess_op(3, 0, 0);
    sess_op(2, 0, 0);
    sess_op(0, 0, 0);

    // Card and provisioning in the same cycle: provisioning is dropped
    prog(7, 9, 55, 1, 6);
    m_addr = 6; m_tries = 0; m_sum = 0; m_phase = 2;
    @(negedge clk);
    check("card_prog_state", 32'(state_o), 32'd2);
    sess_pin(3); sess_op(0, 0, 0);
    sess_card(7); sess_pin(0);
    // Provisioning and a card outside IDLE are both ignored
    prog(7, 9, 55, 0, 0);
    pulse_card(3);
    check("card_ignored_state", 32'(state_o), 32'd3);
    sess_op(3, 0, 0);
    sess_op(3, 0, 3);                 // cancel beats op_valid
    sess_card(7); sess_pin_cancel();  // cancel beats pin_valid

    // Idle behaviour in OP
    sess_card(6); sess_pin(3);
`ifdef ATM_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      cyc(8);
      sess_op(3, 0, 0);
    end
    exp_q.push_back(mk(0, 7, 0, 0));
    drain();
    end_session();
`else
    cyc(40);
    check("no_timeout_state", 32'(state_o), 32'd3);
    check("no_timeout_busy", 32'(busy), 32'd1);
    sess_op(0, 0, 0);
`endif

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      a = 5 + $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0)
        prog(a, $urandom_range(0, 15), $urandom_range(0, 1023), 0, 0);
      sess_card(a);
      while (m_phase == 2) begin
        if ($urandom_range(0, 9) == 0) sess_pin_cancel();
        else if ($urandom_range(0, 2) == 0) sess_pin(ref_pin[a] ^ $urandom_range(1, 15));
        else sess_pin(ref_pin[a]);
      end
      n = $urandom_range(1, 6);
      while (m_phase == 3 && n > 0) begin
        n--;
        bal = ref_bal[a];
        r = $urandom_range(0, 9);
        if (r <= 3) begin
          case ($urandom_range(0, 3))
            0: amt = 0;
            1: amt = $urandom_range(0, 600);
            2: amt = bal;
            default: amt = (bal + 1 > 1023) ? 1023 : bal + 1;
          endcase
          sess_op(2, amt, 0);
        end else if (r <= 6) begin
          case ($urandom_range(0, 3))
            0: amt = $urandom_range(0, 1023);
            1: amt = 1023 - bal;
            2: amt = (1024 - bal > 1023) ? 1023 : 1024 - bal;
            default: amt = $urandom_range(0, 50);
          endcase
          sess_op(1, amt, 0);
        end else if (r == 7) begin
          sess_op(3, 0, 0);
        end else if (r == 8) begin
          sess_op(1 + $urandom_range(0, 1), $urandom_range(0, 1023), 1);
        end else begin
          sess_op($urandom_range(0, 3), 0, 3);
        end
        cyc($urandom_range(0, 4));
      end
      if (m_phase == 3) sess_op(0, 0, 0);
    end

    // Reset mid-session drops provisioned data
    prog(9, 4, 77, 0, 0);
    sess_card(9); sess_pin(4);
    @(negedge clk); rst = 1'b1; #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_state", 32'(state_o), 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < NA; i++) begin ref_pin[i] = 0; ref_bal[i] = 0; ref_lock[i] = 0; end
    m_phase = 0;
    sess_card(9); sess_pin(0);
    sess_op(3, 0, 0);
    sess_op(0, 0, 0);

    cyc(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
